counter_timeshare_ctrl: RTL
===========================

Name: counter_timeshare_ctrl

Overview:
- Round-robin controller that time-shares one up-counter (EN/CLK/RST interface, WIDTH bits) among NREQ requesters.
- Each requester asks for a timed interval of dur cycles. The controller grants one requester at a time, clears the shared counter, and enables it until the count reaches the requested duration.
- It then pulses that requester's done and moves on to the next requester.
- Sits between requesting blocks and a single shared counter instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, counter/duration width; must match the shared counter's WIDTH.
- IDXW, $clog2(NREQ), width of gnt_idx.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- dur  input  NREQ*WIDTH  packed durations; slice i is dur[i*WIDTH +: WIDTH]; sampled on the grant edge only.
- cnt  input  WIDTH  current value of the shared counter.
- cnt_en  output  1  counter enable; combinational from state register and cnt.
- cnt_clr  output  1  drives the counter's RST pin; registered, glitch-free.
- gnt  output  NREQ  one-hot grant; registered.
- gnt_idx  output  IDXW  index of the current or last grantee; registered.
- done  output  NREQ  one-cycle completion pulse to the grantee; registered.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, gnt=0, done=0, gnt_idx=0, rr_ptr=0, dur_q=0, cnt_clr=1. The counter is therefore held at 0 during reset.
- States: IDLE, CLEAR, RUN, DONE.
- cnt_clr register: next value = 1 when next state is IDLE or CLEAR, else 0. It is high in IDLE/CLEAR and low in RUN/DONE, so cnt=0 throughout CLEAR and on the first RUN cycle.
- cnt_en = (state==RUN) && (cnt != dur_q). It is 0 in all other states. The counter stops exactly at dur_q and never wraps.

IDLE:
- If req != 0, select the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
- On that edge: gnt <= onehot(sel), gnt_idx <= sel, dur_q <= dur slice sel, state <= CLEAR.
- If req == 0, stay in IDLE.

CLEAR:
- Next edge: state <= RUN.

RUN:
- If cnt == dur_q, go to DONE on the next edge.
- RUN lasts dur_q+1 cycles; the counter performs exactly dur_q increments.

DONE:
- done[gnt_idx]=1 for exactly this cycle; gnt remains asserted.
- Next edge: gnt <= 0, done <= 0, rr_ptr <= (gnt_idx+1) mod NREQ, state <= IDLE.

Timing:
- Req sampled at edge E0: gnt is high for dur+3 cycles and done is high in the last of them.
- The next grant is sampled in the IDLE cycle that follows, so there is one IDLE cycle between back-to-back grants.

Boundary conditions:
- dur=0: CLEAR then one RUN cycle with cnt_en=0, then DONE. done arrives 3 cycles after E0.
- dur=2^WIDTH-1: counter reaches all-ones and stops; no wrap.
- Abort: req[gnt_idx] deasserted while in CLEAR or RUN. Next edge goes to IDLE, gnt <= 0, no done pulse, rr_ptr advances as for a normal completion.
- req deasserted during DONE does not suppress the done pulse.
- Changes to req of non-granted requesters and to dur during a grant have no effect.
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- RST asserted mid-operation: all outputs return to reset values immediately and the counter is cleared. After release, the controller starts in IDLE with rr_ptr=0.

Test Plan:
- Single req[1]=1, dur1=5, held high: gnt=0010 for 8 cycles; cnt ramps 0→5 and holds 5 for 1 cycle; done=0010 for 1 cycle on the 8th gnt cycle; cnt_clr re-asserts afterwards.
- req=1111 held, all dur=2: grant order 0,1,2,3,0; done pulses exactly 5 cycles apart plus the 1 IDLE cycle; never two gnt bits high.
- dur=0 on requester 2: done[2] 3 cycles after request sampled; cnt_en never 1; cnt stays 0.
- WIDTH=8, dur=255: cnt reaches 255 and holds for 1 cycle with cnt_en=0; no rollover to 0 before cnt_clr.
- Requester 0 with dur=10 drops req when cnt=4: next cycle gnt=0, no done; with req[3] pending, the next grant goes to 3 after rr_ptr=1 scan.
- Async RST pulsed mid-RUN (between clock edges): gnt, done, cnt_en go 0 and cnt_clr goes 1 without a clock edge; after release with req[2] pending, grant goes to 2 via scan from rr_ptr=0.

Source files
------------

// File: rtl/counter_timeshare_ctrl.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters in turn.
// Latency: grant registered one edge after req is seen in IDLE; done pulses dur+3 cycles after that edge.
// Backpressure: requesters wait on req until granted; dropping req[gnt_idx] mid-grant aborts without done.
module counter_timeshare_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dur,
  input  logic [WIDTH-1:0]      cnt,
  output logic                  cnt_en,
  output logic                  cnt_clr,
  output logic [NREQ-1:0]       gnt,
  output logic [IDXW-1:0]       gnt_idx,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [WIDTH-1:0] dur_q;
  logic [IDXW-1:0] sel;
  logic            sel_vld;
  logic            cur_req;
  logic [IDXW-1:0] nxt_ptr;

  // Pick the first requester at or after rr_ptr, wrapping modulo NREQ.
  // The extra index bit keeps rr_ptr+k from overflowing before the wrap subtract.
  always_comb begin
    logic [IDXW:0] idx_w;
    sel     = '0;
    sel_vld = 1'b0;
    idx_w   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (idx_w >= (IDXW+1)'(NREQ)) idx_w = idx_w - (IDXW+1)'(NREQ);
      if (!sel_vld && req[idx_w[IDXW-1:0]]) begin
        sel     = idx_w[IDXW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  // Grantee's live request and the pointer value used after completion or abort.
  always_comb begin
    cur_req = req[gnt_idx];
    nxt_ptr = (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Counter runs only in RUN and stops on reaching the sampled duration, so it never wraps.
  always_comb begin
    cnt_en = (state == RUN) && (cnt != dur_q);
    busy   = (state != IDLE);
  end

  // Arbitration FSM; cnt_clr is set from the next state so it is high exactly in IDLE/CLEAR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      dur_q   <= '0;
      cnt_clr <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr <= 1'b1;
          if (sel_vld) begin
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            gnt_idx <= sel;
            dur_q   <= dur[sel*WIDTH +: WIDTH];
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (!cur_req) begin
            gnt     <= '0;
            rr_ptr  <= nxt_ptr;
            state   <= IDLE;
            cnt_clr <= 1'b1;
          end else begin
            state   <= RUN;
            cnt_clr <= 1'b0;
          end
        end
        RUN: begin
          if (!cur_req) begin
            gnt     <= '0;
            rr_ptr  <= nxt_ptr;
            state   <= IDLE;
            cnt_clr <= 1'b1;
          end else if (cnt == dur_q) begin
            done    <= gnt;
            state   <= DONE;
            cnt_clr <= 1'b0;
          end else begin
            cnt_clr <= 1'b0;
          end
        end
        DONE: begin
          gnt     <= '0;
          done    <= '0;
          rr_ptr  <= nxt_ptr;
          state   <= IDLE;
          cnt_clr <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          done    <= '0;
          cnt_clr <= 1'b1;
        end
      endcase
    end
  end

endmodule
